// File: rtl/dut_or_fifo_pkg.sv
// Shared constants for the OR-FIFO block: register-map addresses and default depths.
// Also holds the pointer-width helper used by every FIFO instance.
package dut_or_fifo_pkg;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] ADDR_A_STATUS = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_B_STATUS = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_Y_STATUS = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_Y_DATA   = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_A_DATA   = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_B_DATA   = 3'd5;

    localparam int DEFAULT_A_DEPTH = 2;
    localparam int DEFAULT_B_DEPTH = 2;
    localparam int DEFAULT_Y_DEPTH = 1;

    // A depth-1 FIFO still needs a one-bit pointer so the vectors stay legal.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dut_sync_fifo.sv
// Single-clock FIFO of 1-bit entries with an occupancy counter.
// Enqueue while full and dequeue while empty are ignored; both flags reflect cycle-start state.
module dut_sync_fifo
    import dut_or_fifo_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enq,
    input  logic deq,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_enq;
    logic             do_deq;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enq && !full;
    assign do_deq = deq && !empty;
    assign dout   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_deq) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dut_or_fifo.sv
// Two input FIFOs (A, B) are paired off, ORed, and pushed into output FIFO Y.
// A small address map exposes writes into A/B and status/data reads of all three FIFOs.
module dut_or_fifo
    import dut_or_fifo_pkg::*;
#(
    parameter int A_DEPTH = DEFAULT_A_DEPTH,
    parameter int B_DEPTH = DEFAULT_B_DEPTH,
    parameter int Y_DEPTH = DEFAULT_Y_DEPTH
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [ADDR_W-1:0] write_address,
    input  logic              write_data,
    input  logic              write_en,
    output logic              write_rdy,
    input  logic [ADDR_W-1:0] read_address,
    input  logic              read_en,
    output logic              read_data,
    output logic              read_rdy
);

    logic enq_a, enq_b, enq_y;
    logic deq_ab, deq_y;
    logic a_dout, b_dout, y_dout;
    logic a_full, b_full, y_full;
    logic a_empty, b_empty, y_empty;

    assign write_rdy = 1'b1;
    assign read_rdy  = 1'b1;

    assign enq_a = write_en && (write_address == ADDR_A_DATA);
    assign enq_b = write_en && (write_address == ADDR_B_DATA);
    assign deq_y = read_en && (read_address == ADDR_Y_DATA);

    // Y full is taken from cycle start, so a same-edge Y read never lets a pair slip through.
    assign deq_ab = !a_empty && !b_empty && !y_full;
    assign enq_y  = deq_ab;

    dut_sync_fifo #(.DEPTH(A_DEPTH)) u_fifo_a (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (enq_a),
        .deq   (deq_ab),
        .din   (write_data),
        .dout  (a_dout),
        .full  (a_full),
        .empty (a_empty)
    );

    dut_sync_fifo #(.DEPTH(B_DEPTH)) u_fifo_b (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (enq_b),
        .deq   (deq_ab),
        .din   (write_data),
        .dout  (b_dout),
        .full  (b_full),
        .empty (b_empty)
    );

    dut_sync_fifo #(.DEPTH(Y_DEPTH)) u_fifo_y (
        .clk   (CLK),
        .rst_n (RST_N),
        .enq   (enq_y),
        .deq   (deq_y),
        .din   (a_dout | b_dout),
        .dout  (y_dout),
        .full  (y_full),
        .empty (y_empty)
    );

    always_comb begin
        read_data = 1'b0;
        case (read_address)
            ADDR_A_STATUS: read_data = !a_full;
            ADDR_B_STATUS: read_data = !b_full;
            ADDR_Y_STATUS: read_data = !y_empty;
            ADDR_Y_DATA:   read_data = !y_empty && y_dout;
            default:       read_data = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dut_or_fifo.sv
// Directed self-checking bench for dut_or_fifo: status reads, OR pairing, backpressure and reset.
// Inputs change on the falling edge; read_data is sampled 1 time unit later.
module tb_dut_or_fifo;

    logic       CLK;
    logic       RST_N;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_data;
    logic       read_rdy;

    int pass_count;
    int check_count;

    dut_or_fifo dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .write_address (write_address),
        .write_data    (write_data),
        .write_en      (write_en),
        .write_rdy     (write_rdy),
        .read_address  (read_address),
        .read_en       (read_en),
        .read_data     (read_data),
        .read_rdy      (read_rdy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic do_write(input logic [2:0] addr, input logic data);
        @(negedge CLK);
        write_address = addr;
        write_data    = data;
        write_en      = 1'b1;
        @(negedge CLK);
        write_en      = 1'b0;
    endtask

    task automatic peek(input logic [2:0] addr, output logic value);
        @(negedge CLK);
        read_address = addr;
        read_en      = 1'b0;
        #1 value = read_data;
    endtask

    // Reads the Y head and dequeues it on the following rising edge.
    task automatic pop(output logic value);
        @(negedge CLK);
        read_address = 3'd3;
        read_en      = 1'b1;
        #1 value = read_data;
        @(negedge CLK);
        read_en      = 1'b0;
    endtask

    task automatic wait_y_valid(input string name);
        logic v;
        int   cyc;
        v   = 1'b0;
        cyc = 0;
        while (v !== 1'b1 && cyc < 20) begin
            peek(3'd2, v);
            cyc++;
        end
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL %s: y_status got %b expected 1 (timeout)", name, v);
        else pass_count++;
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RST_N    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N    = 1'b1;
    endtask

    task automatic test_reset();
        logic       v;
        logic [3:0] exp_status;
        exp_status = 4'b0011;
        RST_N = 1'b0;
        // Stimulus held during reset must leave no trace.
        write_address = 3'd4;
        write_data    = 1'b1;
        write_en      = 1'b1;
        read_address  = 3'd0;
        read_en       = 1'b0;
        repeat (3) @(negedge CLK);
        write_en = 1'b0;
        RST_N    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            peek(3'(i), v);
            check_count++;
            if (v !== exp_status[i]) $display("[TB] FAIL reset_status_%0d: got %b expected %b", i, v, exp_status[i]);
            else pass_count++;
        end
        check_count++;
        if (write_rdy !== 1'b1 || read_rdy !== 1'b1)
            $display("[TB] FAIL rdy_const: got %b%b expected 11", write_rdy, read_rdy);
        else pass_count++;
    endtask

    task automatic test_single_or();
        logic v;
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b0);
        wait_y_valid("single_poll");
        pop(v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL single_y_data: got %b expected 1", v);
        else pass_count++;
        peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL single_y_after_pop: got %b expected 0", v);
        else pass_count++;
    endtask

    task automatic test_all_combos();
        logic       v;
        logic [3:0] a_vals, b_vals, y_exp;
        a_vals = 4'b1100;
        b_vals = 4'b1010;
        y_exp  = 4'b1110;
        for (int i = 0; i < 4; i++) begin
            do_write(3'd4, a_vals[i]);
            do_write(3'd5, b_vals[i]);
            wait_y_valid("combo_poll");
            pop(v);
            check_count++;
            if (v !== y_exp[i]) $display("[TB] FAIL combo_%0d: got %b expected %b", i, v, y_exp[i]);
            else pass_count++;
        end
    endtask

    task automatic test_a_full();
        logic v;
        do_write(3'd4, 1'b1);
        do_write(3'd4, 1'b0);
        peek(3'd0, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL a_full_status: got %b expected 0", v);
        else pass_count++;
        repeat (3) peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL a_only_no_y: got %b expected 0", v);
        else pass_count++;
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b0);
        do_write(3'd5, 1'b0);
        wait_y_valid("a_full_poll1");
        pop(v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL a_full_y1: got %b expected 1", v);
        else pass_count++;
        wait_y_valid("a_full_poll2");
        pop(v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL a_full_y2: got %b expected 0", v);
        else pass_count++;
        // A dropped third write would otherwise pair with this B entry.
        do_write(3'd5, 1'b1);
        repeat (4) peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL a_drop: got %b expected 0", v);
        else pass_count++;
        apply_reset();
    endtask

    task automatic test_y_backpressure();
        logic v;
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b1);
        do_write(3'd4, 1'b0);
        do_write(3'd5, 1'b0);
        do_write(3'd4, 1'b0);
        do_write(3'd5, 1'b1);
        repeat (3) peek(3'd0, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL bp_a_held: got %b expected 0", v);
        else pass_count++;
        peek(3'd1, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL bp_b_held: got %b expected 0", v);
        else pass_count++;
        peek(3'd2, v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL bp_y_full: got %b expected 1", v);
        else pass_count++;
        pop(v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL bp_y1: got %b expected 1", v);
        else pass_count++;
        wait_y_valid("bp_poll2");
        pop(v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL bp_y2: got %b expected 0", v);
        else pass_count++;
        wait_y_valid("bp_poll3");
        pop(v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL bp_y3: got %b expected 1", v);
        else pass_count++;
        peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL bp_drained: got %b expected 0", v);
        else pass_count++;
    endtask

    task automatic test_ignored_addresses();
        logic       v;
        logic [2:0] addrs [6];
        addrs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd6, 3'd7};
        foreach (addrs[i]) do_write(addrs[i], 1'b1);
        do_write(3'd5, 1'b1);
        repeat (3) peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL ignored_writes: got %b expected 0", v);
        else pass_count++;
        do_write(3'd4, 1'b0);
        wait_y_valid("ignored_poll");
        // read_en at a status address must not dequeue Y.
        @(negedge CLK);
        read_address = 3'd2;
        read_en      = 1'b1;
        @(negedge CLK);
        read_en      = 1'b0;
        for (int a = 4; a < 8; a++) begin
            peek(3'(a), v);
            check_count++;
            if (v !== 1'b0) $display("[TB] FAIL read_zero_%0d: got %b expected 0", a, v);
            else pass_count++;
        end
        pop(v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL no_side_effect_y: got %b expected 1", v);
        else pass_count++;
    endtask

    task automatic test_reset_mid();
        logic       v;
        logic [3:0] exp_status;
        exp_status = 4'b0011;
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b1);
        do_write(3'd4, 1'b1);
        do_write(3'd5, 1'b1);
        do_write(3'd4, 1'b1);
        peek(3'd2, v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL mid_pre_y: got %b expected 1", v);
        else pass_count++;
        @(negedge CLK);
        RST_N = 1'b0;
        for (int i = 0; i < 4; i++) begin
            read_address = 3'(i);
            #1;
            check_count++;
            if (read_data !== exp_status[i]) $display("[TB] FAIL mid_reset_status_%0d: got %b expected %b", i, read_data, exp_status[i]);
            else pass_count++;
        end
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (4) peek(3'd2, v);
        check_count++;
        if (v !== 1'b0) $display("[TB] FAIL mid_no_stale_y: got %b expected 0", v);
        else pass_count++;
        peek(3'd0, v);
        check_count++;
        if (v !== 1'b1) $display("[TB] FAIL mid_a_empty: got %b expected 1", v);
        else pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_single_or();
        test_all_combos();
        test_a_full();
        test_y_backpressure();
        test_ignored_addresses();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/dut_or_fifo.md
DUT_OR_FIFO -- requirements
Module: dut_or_fifo

Interface
REQ-001 Parameter A_DEPTH, default 2: capacity of input FIFO A (1-bit entries).
REQ-002 Parameter B_DEPTH, default 2: capacity of input FIFO B (1-bit entries).
REQ-003 Parameter Y_DEPTH, default 1: capacity of output FIFO Y (1-bit entries).
REQ-004 CLK  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous and active-low.
REQ-006 write_address  in  3  write target select.
REQ-007 write_data  in  1  write payload.
REQ-008 write_en  in  1  write strobe, sampled at the CLK rising edge.
REQ-009 write_rdy  out  1  write method ready; SHALL be constant 1.
REQ-010 read_address  in  3  read source select.
REQ-011 read_en  in  1  read strobe; dequeues Y when read_address=3.
REQ-012 read_data  out  1  read result; combinational from read_address and current state.
REQ-013 read_rdy  out  1  read method ready; SHALL be constant 1.

Function
REQ-014 write_en=1 with write_address=4 SHALL enqueue write_data into A if A is not full; otherwise the write SHALL be dropped silently.
REQ-015 write_en=1 with write_address=5 SHALL enqueue write_data into B if B is not full; otherwise the write SHALL be dropped.
REQ-016 Writes to any other address SHALL be ignored.
REQ-017 read_data SHALL return, by address:
- 0: A not-full.
- 1: B not-full.
- 2: Y not-empty.
- 3: head of Y, or 0 if Y is empty.
- 4-7: 0.
REQ-018 read_en=1 with read_address=3 and Y not empty SHALL dequeue Y at the edge; with Y empty, no state SHALL change.
REQ-019 Reads at addresses 0-2 and 4-7 SHALL have no side effects, whatever the value of read_en.
REQ-020 In any cycle where A is not empty, B is not empty and Y is not full, the block SHALL:
- dequeue one entry from A and one from B;
- enqueue (A head OR B head) into Y, at the same edge.
REQ-021 Y "not full" for REQ-020 SHALL be evaluated before the same-edge dequeue (no pass-through).
REQ-022 Latency:
- a write to A at edge n and a write to B at edge n make Y valid from edge n+1;
- therefore address 2 reads 1 in the cycle after edge n+1.
REQ-023 Simultaneous write-to-A and OR-dequeue of A in the same cycle SHALL both take effect when A is full at cycle start only if REQ-014 permits; the full flag is evaluated at cycle start.
REQ-024 FIFOs SHALL preserve order and wrap their pointers modulo depth.

Reset
REQ-025 While RST_N=0, all FIFOs SHALL be emptied asynchronously.
REQ-026 After reset, the status reads SHALL be:
- address 0 and address 1 read 1;
- address 2 and address 3 read 0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight data; no OR result SHALL be produced from pre-reset entries.
REQ-028 Stimulus SHALL be ignored until RST_N is sampled high.

Structure
REQ-029 A shared package SHALL hold:
- the address constants: ADDR_A_STATUS=0, ADDR_B_STATUS=1, ADDR_Y_STATUS=2, ADDR_Y_DATA=3, ADDR_A_DATA=4, ADDR_B_DATA=5;
- the default depths.
REQ-030 One parameterised sub-module, dut_sync_fifo, SHALL provide:
- ports enq, deq, din, dout, full, empty;
- asynchronous active-low reset;
- three instances (A, B, Y).

Verification
REQ-031 Release reset, then read addresses 0, 1, 2, 3 -> read_data = 1, 1, 0, 0.
REQ-032 Write A=1 (addr 4) and B=0 (addr 5), poll addr 2 until 1, read addr 3 with read_en -> returns 1; addr 2 then reads 0.
REQ-033 Run all four (A, B) combinations in sequence -> Y outputs 0, 1, 1, 1 in order.
REQ-034 Write A twice, no B -> addr 0 reads 0 (full) and addr 2 stays 0; a third A write is dropped; then two B writes -> exactly two Y results, in order.
REQ-035 Fill Y without reading it, then write more A/B pairs -> A and B hold their data and do not drain until Y is dequeued.
REQ-036 Assert RST_N low with A, B and Y non-empty -> status resets immediately to 1, 1, 0, 0; no stale Y output after reset.
